pbvi_backup_proj: RTL and testbench
===================================

Name: pbvi_backup_proj

Overview:
- Parametrised, sequential successor to the PBVI backup step-1 projection stage.
- For every action a, observation o, alpha vector j and state s it computes gamma[a][o][j][s] = discount * sum over s' of T[a][s][s'] * O[a][s'][o] * alpha[j][s'].
- Uses a single time-multiplexed MAC datapath instead of a fully unrolled combinational array.
- Results stream out over a valid/ready handshake to the cross-sum / argmax stage.

Parameters:
- NS, 2, number of states.
- NA, 3, number of actions.
- NO, 2, number of observations.
- NJ, 16, number of alpha vectors.
- W, 16, data width (unsigned fixed point).
- FRAC, 15, fraction bits (Q1.15 by default; 1.0 = 0x8000).
- ACCW, W+8, accumulator width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a projection pass; sampled only in IDLE
- discount  in  W  discount factor
- alpha  in  W x [NJ][NS]  alpha vectors
- trans  in  W x [NA][NS][NS]  T[a][s][s']
- observe  in  W x [NA][NS][NO]  O[a][s'][o]
- busy  out  1  high from the cycle after an accepted start until done
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  W  gamma value
- out_a / out_o / out_j / out_s  out  clog2 widths (min 1)  indices of out_data
- out_last  out  1  marks the final element of the pass
- done  out  1  single-cycle pulse after the last transfer

Behaviour:
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- Reset values:
  - FSM = IDLE.
  - busy, out_valid, out_last and done = 0.
  - out_data and all index outputs = 0.
  - Accumulator and counters = 0.
- Input stability: alpha, trans, observe and discount must stay stable while busy. They are read live and not latched.
- FSM states: IDLE, MAC, SCALE, EMIT, FIN.
  - IDLE: start=1 -> MAC. Index counters a, o, j, s and s' are cleared, accumulator cleared.
  - MAC: one term per cycle.
    - p1 = (T[a][s][s'] * O[a][s'][o]) >> FRAC, truncated.
    - p2 = (p1 * alpha[j][s']) >> FRAC, truncated.
    - acc += p2.
    - After s' = NS-1 -> SCALE.
  - SCALE: r = (acc * discount) >> FRAC. out_data = min(r, 2^W-1), i.e. it saturates. Indices are registered. -> EMIT.
  - EMIT: out_valid=1. out_data and indices hold stable until out_ready=1.
    - On the handshake, if the element is not the last, advance indices -> MAC, with the accumulator cleared and s'=0.
    - On the handshake, if the element is the last -> FIN.
  - FIN: done=1 for this one cycle, busy falls -> IDLE.
- Index order: s fastest, then j, then o, then a slowest.
- out_last=1 only in EMIT for element (NA-1, NO-1, NJ-1, NS-1).
- Per-element latency with out_ready tied high: NS MAC cycles + 1 SCALE + 1 EMIT = NS+2 cycles.
- Pass latency: NA*NO*NJ*NS*(NS+2) cycles from start acceptance to the last handshake, then 1 FIN cycle.
- Accumulator: ACCW bits, saturating add (clamps at 2^ACCW-1), no wrap-around.
- start while not in IDLE: ignored, no restart, no error.
- start asserted in the FIN cycle: ignored. A new start is accepted in the following IDLE cycle.
- out_ready asserted outside EMIT: no effect.
- Back-pressure: the MAC does not advance while EMIT is stalled. There is no output buffering.
- Reset mid-pass: all state returns to its reset value immediately. No done pulse and no partial results.
- Degenerate sizes: any dimension = 1 is legal. Index port width is then 1 and that index is always 0.

Test Plan:
- Identity T, all O=0x8000, all alpha=0x4000, discount=0x8000, NS=2 default sizes -> 192 results each 0x4000, indices in s/j/o/a order, out_last only on the 192nd, done one cycle after it.
- Same stimulus but discount=0x4000 -> every result 0x2000; with out_ready high each element is spaced exactly 4 cycles apart.
- T[a][s][*]=0x8000 for both s', O=0x8000, alpha=0xFFFF, discount=0x8000 -> r = 0x1FFFE, out_data saturates to 0xFFFF.
- Toggle out_ready randomly, including 10 low cycles mid-element -> out_data and indices stable while stalled, no lost or duplicated element, total count still 192.
- Pulse start in MAC and in EMIT -> ignored, pass completes unchanged. Pulse start during FIN -> ignored, next IDLE start accepted.
- Deassert rst_n at element 50 -> busy, out_valid and done go to 0 asynchronously. A fresh start then yields a full correct 192-element pass.

Source files
------------

// File: rtl/pbvi_backup_proj.sv
// pbvi_backup_proj: sequential PBVI backup projection stage.
// Computes gamma[a][o][j][s] = discount * sum_s' T[a][s][s'] * O[a][s'][o] * alpha[j][s']
// with one time-multiplexed MAC, streaming each result over valid/ready.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a pass (sampled only in IDLE)
//   discount            discount factor (Q format, FRAC fraction bits)
//   alpha/trans/observe model inputs, read live, must be stable while busy
//   busy                pass in progress
//   out_valid/out_ready result handshake
//   out_data            saturated gamma value
//   out_a/o/j/s         indices of out_data
//   out_last            final element of the pass
//   done                one-cycle pulse after the last transfer
module pbvi_backup_proj #(
    parameter int NS   = 2,
    parameter int NA   = 3,
    parameter int NO   = 2,
    parameter int NJ   = 16,
    parameter int W    = 16,
    parameter int FRAC = 15,
    parameter int ACCW = W + 8,
    localparam int AW  = (NA > 1) ? $clog2(NA) : 1,
    localparam int OW  = (NO > 1) ? $clog2(NO) : 1,
    localparam int JW  = (NJ > 1) ? $clog2(NJ) : 1,
    localparam int SW  = (NS > 1) ? $clog2(NS) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [W-1:0]                       discount,
    input  logic [NJ-1:0][NS-1:0][W-1:0]       alpha,
    input  logic [NA-1:0][NS-1:0][NS-1:0][W-1:0] trans,
    input  logic [NA-1:0][NS-1:0][NO-1:0][W-1:0] observe,
    output logic                               busy,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [W-1:0]                       out_data,
    output logic [AW-1:0]                      out_a,
    output logic [OW-1:0]                      out_o,
    output logic [JW-1:0]                      out_j,
    output logic [SW-1:0]                      out_s,
    output logic                               out_last,
    output logic                               done
);
    localparam int PW   = 3 * W;
    localparam int SUMW = ((PW > ACCW) ? PW : ACCW) + 1;
    localparam int RW   = ACCW + W;

    typedef enum logic [2:0] {IDLE, MAC, SCALE, EMIT, FIN} state_t;

    state_t state, state_nxt;

    logic [AW-1:0]   a_q;
    logic [OW-1:0]   o_q;
    logic [JW-1:0]   j_q;
    logic [SW-1:0]   s_q;
    logic [SW-1:0]   sp_q;
    logic [ACCW-1:0] acc;

    logic [PW-1:0]   prod1, p1, prod2, p2;
    logic [SUMW-1:0] sum;
    logic [ACCW-1:0] acc_sat;
    logic [RW-1:0]   prod3, r;
    logic [W-1:0]    r_sat;

    logic last_s, last_j, last_o, last_a, last_sp, last_all;

    // Two truncating Q-format multiplies feeding a saturating accumulate.
    always_comb begin
        prod1   = PW'(trans[a_q][s_q][sp_q]) * PW'(observe[a_q][sp_q][o_q]);
        p1      = prod1 >> FRAC;
        prod2   = p1 * PW'(alpha[j_q][sp_q]);
        p2      = prod2 >> FRAC;
        sum     = SUMW'(acc) + SUMW'(p2);
        acc_sat = (sum > SUMW'({ACCW{1'b1}})) ? {ACCW{1'b1}} : sum[ACCW-1:0];
        prod3   = RW'(acc) * RW'(discount);
        r       = prod3 >> FRAC;
        r_sat   = (r > RW'({W{1'b1}})) ? {W{1'b1}} : r[W-1:0];
    end

    assign last_s   = (s_q  == SW'(NS - 1));
    assign last_j   = (j_q  == JW'(NJ - 1));
    assign last_o   = (o_q  == OW'(NO - 1));
    assign last_a   = (a_q  == AW'(NA - 1));
    assign last_sp  = (sp_q == SW'(NS - 1));
    assign last_all = last_s && last_j && last_o && last_a;

    assign busy      = (state != IDLE);
    assign out_valid = (state == EMIT);
    assign done      = (state == FIN);
    assign out_last  = (state == EMIT) && (out_a == AW'(NA - 1)) && (out_o == OW'(NO - 1))
                       && (out_j == JW'(NJ - 1)) && (out_s == SW'(NS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MAC;
            MAC:     if (last_sp) state_nxt = SCALE;
            SCALE:   state_nxt = EMIT;
            EMIT:    if (out_ready) state_nxt = last_all ? FIN : MAC;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            o_q      <= '0;
            j_q      <= '0;
            s_q      <= '0;
            sp_q     <= '0;
            acc      <= '0;
            out_data <= '0;
            out_a    <= '0;
            out_o    <= '0;
            out_j    <= '0;
            out_s    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_q  <= '0;
                    o_q  <= '0;
                    j_q  <= '0;
                    s_q  <= '0;
                    sp_q <= '0;
                    acc  <= '0;
                end
                MAC: begin
                    acc  <= acc_sat;
                    sp_q <= last_sp ? '0 : sp_q + 1'b1;
                end
                SCALE: begin
                    out_data <= r_sat;
                    out_a    <= a_q;
                    out_o    <= o_q;
                    out_j    <= j_q;
                    out_s    <= s_q;
                end
                EMIT: if (out_ready && !last_all) begin
                    acc  <= '0;
                    sp_q <= '0;
                    // s fastest, then j, then o, a slowest
                    if (!last_s) s_q <= s_q + 1'b1;
                    else begin
                        s_q <= '0;
                        if (!last_j) j_q <= j_q + 1'b1;
                        else begin
                            j_q <= '0;
                            if (!last_o) o_q <= o_q + 1'b1;
                            else begin
                                o_q <= '0;
                                a_q <= a_q + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pbvi_backup_proj.sv
// Self-checking bench for pbvi_backup_proj: scoreboard of expected gamma
// elements built from a reference model, compared at each handshake.
module tb_pbvi_backup_proj;
    localparam int NS = 2, NA = 3, NO = 2, NJ = 16, W = 16, FRAC = 15;
    localparam int TOTAL = NA * NO * NJ * NS;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  a;
        logic        o;
        logic [3:0]  j;
        logic        s;
        logic        last;
    } exp_t;

    logic clk, rst_n, start, out_ready;
    logic [W-1:0] discount;
    logic [NJ-1:0][NS-1:0][W-1:0] alpha;
    logic [NA-1:0][NS-1:0][NS-1:0][W-1:0] trans;
    logic [NA-1:0][NS-1:0][NO-1:0][W-1:0] observe;
    logic busy, out_valid, out_last, done;
    logic [W-1:0] out_data;
    logic [1:0] out_a;
    logic out_o;
    logic [3:0] out_j;
    logic out_s;

    exp_t q[$];
    int checks = 0, errors = 0;
    int n_hs = 0, cyc = 0, last_cyc = 0, stall_cnt = 0;
    bit spacing_chk = 0, done_pending = 0, prev_done = 0, rdy_rand = 0, stalled_once = 0;

    pbvi_backup_proj #(.NS(NS), .NA(NA), .NO(NO), .NJ(NJ), .W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .discount(discount),
        .alpha(alpha), .trans(trans), .observe(observe),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_a(out_a), .out_o(out_o), .out_j(out_j),
        .out_s(out_s), .out_last(out_last), .done(done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] model(int a, int o, int j, int s);
        longint acc = 0, p1, p2, r;
        for (int sp = 0; sp < NS; sp++) begin
            p1 = (longint'(trans[a][s][sp]) * longint'(observe[a][sp][o])) >> FRAC;
            p2 = (p1 * longint'(alpha[j][sp])) >> FRAC;
            acc = acc + p2;
            if (acc > 64'hFFFFFF) acc = 64'hFFFFFF;
        end
        r = (acc * longint'(discount)) >> FRAC;
        return (r > 65535) ? 16'hFFFF : r[15:0];
    endfunction

    task automatic push_all();
        exp_t e;
        for (int a = 0; a < NA; a++)
            for (int o = 0; o < NO; o++)
                for (int j = 0; j < NJ; j++)
                    for (int s = 0; s < NS; s++) begin
                        e.data = model(a, o, j, s);
                        e.a = a[1:0];
                        e.o = o[0];
                        e.j = j[3:0];
                        e.s = s[0];
                        e.last = (a == NA-1) && (o == NO-1) && (j == NJ-1) && (s == NS-1);
                        q.push_back(e);
                    end
    endtask

    task automatic run_pass();
        int k = 0;
        n_hs = 0;
        last_cyc = 0;
        push_all();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        while (!done && k < 6000) begin @(negedge clk); k++; end
        chk("pass_done_seen", done, 1);
        chk("pass_count", n_hs, TOTAL);
        chk("queue_empty", q.size(), 0);
    endtask

    task automatic set_uniform(input logic [15:0] tdiag, input logic [15:0] toff,
                               input logic [15:0] ov, input logic [15:0] av, input logic [15:0] d);
        for (int a = 0; a < NA; a++)
            for (int s = 0; s < NS; s++)
                for (int t = 0; t < NS; t++) trans[a][s][t] = (s == t) ? tdiag : toff;
        for (int a = 0; a < NA; a++)
            for (int s = 0; s < NS; s++)
                for (int o = 0; o < NO; o++) observe[a][s][o] = ov;
        for (int j = 0; j < NJ; j++)
            for (int s = 0; s < NS; s++) alpha[j][s] = av;
        discount = d;
    endtask

    initial begin
        exp_t e;
        int k;
        rst_n = 0; start = 0; out_ready = 0;
        set_uniform(16'h8000, 16'h0000, 16'h8000, 16'h4000, 16'h8000);

        fork
            // monitor / scoreboard
            forever begin
                @(negedge clk);
                cyc++;
                if (prev_done) chk("done_single_cycle", done, 0);
                prev_done = done;
                if (done_pending) begin chk("done_after_last", done, 1); done_pending = 0; end
                if (out_valid) begin
                    if (q.size() == 0) chk("unexpected_output", out_valid, 0);
                    else begin
                        chk("data", out_data, q[0].data);
                        chk("idx_a", out_a, q[0].a);
                        chk("idx_o", out_o, q[0].o);
                        chk("idx_j", out_j, q[0].j);
                        chk("idx_s", out_s, q[0].s);
                        chk("last", out_last, q[0].last);
                        if (out_ready) begin
                            e = q.pop_front();
                            n_hs++;
                            if (spacing_chk && n_hs > 1) chk("spacing", cyc - last_cyc, 4);
                            last_cyc = cyc;
                            if (e.last) done_pending = 1;
                        end
                    end
                end
            end
            // ready driver
            forever begin
                @(posedge clk); #1;
                if (!rdy_rand) out_ready = 1;
                else if (stall_cnt > 0) begin out_ready = 0; stall_cnt--; end
                else if (!stalled_once && n_hs >= 20 && out_valid) begin
                    stalled_once = 1; stall_cnt = 9; out_ready = 0;
                end else out_ready = 1'($urandom_range(0, 1));
            end
        join_none

        // reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", {out_a, out_o, out_j, out_s}, 0);
        @(negedge clk); rst_n = 1;

        // identity T, discount 1.0 -> 0x4000 everywhere
        run_pass();

        // discount 0.5 -> 0x2000, element spacing 4 cycles
        discount = 16'h4000;
        spacing_chk = 1;
        run_pass();
        spacing_chk = 0;

        // output saturation: r = 0x1FFFE
        set_uniform(16'h8000, 16'h8000, 16'h8000, 16'hFFFF, 16'h8000);
        run_pass();

        // random data with random back-pressure and a 10-cycle stall
        for (int a = 0; a < NA; a++)
            for (int s = 0; s < NS; s++)
                for (int t = 0; t < NS; t++) trans[a][s][t] = 16'($urandom);
        for (int a = 0; a < NA; a++)
            for (int s = 0; s < NS; s++)
                for (int o = 0; o < NO; o++) observe[a][s][o] = 16'($urandom);
        for (int j = 0; j < NJ; j++)
            for (int s = 0; s < NS; s++) alpha[j][s] = 16'($urandom);
        discount = 16'h7333;
        rdy_rand = 1;
        run_pass();
        chk("stall_happened", stalled_once, 1);
        rdy_rand = 0;

        // start pulses in EMIT and MAC are ignored
        n_hs = 0;
        fork
            run_pass();
            begin
                k = 0;
                while (n_hs < 5 && k < 3000) begin @(negedge clk); k++; end
                while (!out_valid && k < 3000) begin @(negedge clk); k++; end
                start = 1;
                @(posedge clk); #1;
                @(posedge clk); #1 start = 0;
            end
        join

        // start in FIN is ignored
        start = 1;
        @(posedge clk); #1 start = 0;
        @(negedge clk);
        chk("fin_start_ignored", busy, 0);
        run_pass();

        // reset mid-pass at element 50
        set_uniform(16'h8000, 16'h0000, 16'h8000, 16'h4000, 16'h8000);
        n_hs = 0;
        push_all();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        k = 0;
        while (n_hs < 50 && k < 3000) begin @(negedge clk); k++; end
        chk("pre_reset_busy", busy, 1);
        #2 rst_n = 0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_done", done, 0);
        q.delete();
        done_pending = 0;
        @(posedge clk); #1 rst_n = 1;
        repeat (3) @(negedge clk);
        chk("no_done_after_reset", done, 0);
        chk("idle_after_reset", busy, 0);
        run_pass();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
